// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve unit: condition codes and the
// 2-bit saturating-counter states held in the pattern history table.
package branch_resolve_unit_pkg;

   localparam logic [2:0] COND_EQ     = 3'd0;
   localparam logic [2:0] COND_NE     = 3'd1;
   localparam logic [2:0] COND_GE     = 3'd2;
   localparam logic [2:0] COND_LE     = 3'd3;
   localparam logic [2:0] COND_GT     = 3'd4;
   localparam logic [2:0] COND_LT     = 3'd5;
   localparam logic [2:0] COND_CARRY  = 3'd6;
   localparam logic [2:0] COND_ALWAYS = 3'd7;

   localparam logic [1:0] PHT_SNT = 2'b00;
   localparam logic [1:0] PHT_WNT = 2'b01;
   localparam logic [1:0] PHT_WT  = 2'b10;
   localparam logic [1:0] PHT_ST  = 2'b11;

endpackage

// File: rtl/branch_pht.sv
// Pattern history table: two asynchronous read ports (fetch lookup and EX
// read-modify-write) and one synchronous write port; resets every entry to WNT.
module branch_pht
   import branch_resolve_unit_pkg::*;
#(
   parameter int PHT_IDX_W = 4
) (
   input  logic                 clk_pi,
   input  logic                 reset_pi,
   input  logic [PHT_IDX_W-1:0] rd_a_idx_pi,
   output logic [1:0]           rd_a_data_po,
   input  logic [PHT_IDX_W-1:0] rd_b_idx_pi,
   output logic [1:0]           rd_b_data_po,
   input  logic                 wr_en_pi,
   input  logic [PHT_IDX_W-1:0] wr_idx_pi,
   input  logic [1:0]           wr_data_pi
);

   localparam int DEPTH = 1 << PHT_IDX_W;

   logic [1:0] pht_q [DEPTH];
   logic [1:0] pht_d [DEPTH];

   assign rd_a_data_po = pht_q[rd_a_idx_pi];
   assign rd_b_data_po = pht_q[rd_b_idx_pi];

   always_comb begin
      pht_d = pht_q;
      if (wr_en_pi) pht_d[wr_idx_pi] = wr_data_pi;
   end

   always_ff @(posedge clk_pi) begin
      if (reset_pi) begin
         for (int i = 0; i < DEPTH; i++) pht_q[i] <= PHT_WNT;
      end else begin
         pht_q <= pht_d;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves one conditional branch per cycle in EX, trains the PHT that fetch
// reads for prediction, and registers taken/mispredict/redirect plus a mispredict count.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int PC_W      = 16,
   parameter int PHT_IDX_W = 4,
   parameter int CNT_W     = 16
) (
   input  logic              clk_pi,
   input  logic              reset_pi,
   input  logic [PC_W-1:0]   fetch_pc_pi,
   output logic              predict_taken_po,
   input  logic              br_valid_pi,
   input  logic [2:0]        br_cond_pi,
   input  logic              br_signed_pi,
   input  logic [PC_W-1:0]   br_pc_pi,
   input  logic [PC_W-1:0]   br_target_pi,
   input  logic              br_pred_taken_pi,
   input  logic [DATA_W-1:0] reg1_data_pi,
   input  logic [DATA_W-1:0] reg2_data_pi,
   input  logic              alu_carry_bit_pi,
   input  logic              stall_pi,
   output logic              is_branch_taken_po,
   output logic              mispredict_po,
   output logic [PC_W-1:0]   redirect_pc_po,
   output logic [CNT_W-1:0]  mispredict_cnt_po
);

   function automatic logic [1:0] pht_step(input logic [1:0] ctr, input logic taken);
      if (taken) return (ctr == PHT_ST) ? PHT_ST : ctr + 2'd1;
      return (ctr == PHT_SNT) ? PHT_SNT : ctr - 2'd1;
   endfunction

   function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + CNT_W'(1);
   endfunction

   logic                   vld_p0;
   logic                   cond_true_p0;
   logic signed [DATA_W:0] op_a_p0;
   logic signed [DATA_W:0] op_b_p0;
   logic [1:0]             fetch_ctr;
   logic [1:0]             br_ctr_p0;
   logic                   unused_fetch_hi;

   logic              taken_p1_q,       taken_p1_d;
   logic              mispredict_p1_q,  mispredict_p1_d;
   logic [PC_W-1:0]   redirect_pc_p1_q, redirect_pc_p1_d;
   logic [CNT_W-1:0]  mis_cnt_q,        mis_cnt_d;

   assign vld_p0          = br_valid_pi & ~stall_pi;
   assign unused_fetch_hi = ^fetch_pc_pi[PC_W-1:PHT_IDX_W];

   // Stage p0: condition evaluation. One extra MSB (sign or zero) lets a single
   // signed compare serve both the signed and unsigned modes.
   always_comb begin
      op_a_p0 = {br_signed_pi & reg1_data_pi[DATA_W-1], reg1_data_pi};
      op_b_p0 = {br_signed_pi & reg2_data_pi[DATA_W-1], reg2_data_pi};
      cond_true_p0 = 1'b0;
      case (br_cond_pi)
         COND_EQ:     cond_true_p0 = (reg1_data_pi == reg2_data_pi);
         COND_NE:     cond_true_p0 = (reg1_data_pi != reg2_data_pi);
         COND_GE:     cond_true_p0 = (op_a_p0 >= op_b_p0);
         COND_LE:     cond_true_p0 = (op_a_p0 <= op_b_p0);
         COND_GT:     cond_true_p0 = (op_a_p0 >  op_b_p0);
         COND_LT:     cond_true_p0 = (op_a_p0 <  op_b_p0);
         COND_CARRY:  cond_true_p0 = alu_carry_bit_pi;
         COND_ALWAYS: cond_true_p0 = 1'b1;
      endcase
   end

   branch_pht #(
      .PHT_IDX_W (PHT_IDX_W)
   ) u_pht (
      .clk_pi       (clk_pi),
      .reset_pi     (reset_pi),
      .rd_a_idx_pi  (fetch_pc_pi[PHT_IDX_W-1:0]),
      .rd_a_data_po (fetch_ctr),
      .rd_b_idx_pi  (br_pc_pi[PHT_IDX_W-1:0]),
      .rd_b_data_po (br_ctr_p0),
      .wr_en_pi     (vld_p0),
      .wr_idx_pi    (br_pc_pi[PHT_IDX_W-1:0]),
      .wr_data_pi   (pht_step(br_ctr_p0, cond_true_p0))
   );

   assign predict_taken_po = fetch_ctr[1];

   always_comb begin
      taken_p1_d       = taken_p1_q;
      mispredict_p1_d  = mispredict_p1_q;
      redirect_pc_p1_d = redirect_pc_p1_q;
      mis_cnt_d        = mis_cnt_q;
      if (!stall_pi) begin
         taken_p1_d      = vld_p0 & cond_true_p0;
         mispredict_p1_d = vld_p0 & (cond_true_p0 != br_pred_taken_pi);
         if (vld_p0) begin
            redirect_pc_p1_d = cond_true_p0 ? br_target_pi : br_pc_pi + PC_W'(1);
            if (cond_true_p0 != br_pred_taken_pi) mis_cnt_d = cnt_sat_inc(mis_cnt_q);
         end
      end
   end

   // Stage p1: registered resolve outputs
   always_ff @(posedge clk_pi) begin
      if (reset_pi) begin
         taken_p1_q       <= 1'b0;
         mispredict_p1_q  <= 1'b0;
         redirect_pc_p1_q <= '0;
         mis_cnt_q        <= '0;
      end else begin
         taken_p1_q       <= taken_p1_d;
         mispredict_p1_q  <= mispredict_p1_d;
         redirect_pc_p1_q <= redirect_pc_p1_d;
         mis_cnt_q        <= mis_cnt_d;
      end
   end

   assign is_branch_taken_po = taken_p1_q;
   assign mispredict_po      = mispredict_p1_q;
   assign redirect_pc_po     = redirect_pc_p1_q;
   assign mispredict_cnt_po  = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; a narrow counter width keeps the
// saturation case short.
module tb_branch_resolve_unit;

   localparam int DATA_W = 16;
   localparam int PC_W   = 16;
   localparam int IDX_W  = 4;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [PC_W-1:0]   fetch_pc = '0;
   logic              predict_taken;
   logic              br_valid = 1'b0;
   logic [2:0]        br_cond = '0;
   logic              br_signed = 1'b0;
   logic [PC_W-1:0]   br_pc = '0;
   logic [PC_W-1:0]   br_target = '0;
   logic              br_pred = 1'b0;
   logic [DATA_W-1:0] reg1 = '0;
   logic [DATA_W-1:0] reg2 = '0;
   logic              carry = 1'b0;
   logic              stall = 1'b0;
   logic              taken;
   logic              mispredict;
   logic [PC_W-1:0]   redirect_pc;
   logic [CNT_W-1:0]  mis_cnt;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(
      .DATA_W(DATA_W), .PC_W(PC_W), .PHT_IDX_W(IDX_W), .CNT_W(CNT_W)
   ) dut (
      .clk_pi(clk), .reset_pi(reset), .fetch_pc_pi(fetch_pc), .predict_taken_po(predict_taken),
      .br_valid_pi(br_valid), .br_cond_pi(br_cond), .br_signed_pi(br_signed), .br_pc_pi(br_pc),
      .br_target_pi(br_target), .br_pred_taken_pi(br_pred), .reg1_data_pi(reg1), .reg2_data_pi(reg2),
      .alu_carry_bit_pi(carry), .stall_pi(stall), .is_branch_taken_po(taken),
      .mispredict_po(mispredict), .redirect_pc_po(redirect_pc), .mispredict_cnt_po(mis_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resolve(input logic [2:0] cond, input logic sgn, input logic [15:0] pc,
                          input logic [15:0] tgt, input logic pred,
                          input logic [15:0] a, input logic [15:0] b, input logic cy);
      br_cond = cond; br_signed = sgn; br_pc = pc; br_target = tgt; br_pred = pred;
      reg1 = a; reg2 = b; carry = cy; br_valid = 1'b1;
      tick();
      br_valid = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic t, input logic m,
                          input logic [15:0] rpc, input logic [3:0] c);
      chk({tag, ".taken"}, 32'(taken), 32'(t));
      chk({tag, ".mis"},   32'(mispredict), 32'(m));
      chk({tag, ".redir"}, 32'(redirect_pc), 32'(rpc));
      chk({tag, ".cnt"},   32'(mis_cnt), 32'(c));
   endtask

   task automatic chk_pht_all_wnt(input string tag);
      for (int i = 0; i < 16; i++) begin
         fetch_pc = 16'(i);
         #1;
         chk($sformatf("%s.pred[%0d]", tag, i), 32'(predict_taken), 32'd0);
      end
   endtask

   task automatic chk_pred(input string tag, input logic [15:0] pc, input logic exp);
      fetch_pc = pc;
      #1;
      chk(tag, 32'(predict_taken), 32'(exp));
   endtask

   initial begin
      // 1: reset state
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      chk_out("reset", 1'b0, 1'b0, 16'h0000, 4'd0);
      chk_pht_all_wnt("reset");

      // 2: EQ taken, predicted not-taken
      resolve(3'd0, 1'b0, 16'h0005, 16'h0040, 1'b0, 16'h1234, 16'h1234, 1'b0);
      chk_out("eq", 1'b1, 1'b1, 16'h0040, 4'd1);
      tick();
      chk_out("idle", 1'b0, 1'b0, 16'h0040, 4'd1);
      chk_pred("pht5", 16'h0005, 1'b1);

      // 3: signed vs unsigned compares, prediction matching so the count holds
      resolve(3'd4, 1'b1, 16'h0010, 16'h0100, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
      chk_out("gt_s", 1'b0, 1'b0, 16'h0011, 4'd1);
      resolve(3'd4, 1'b0, 16'h0010, 16'h0100, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
      chk_out("gt_u", 1'b1, 1'b0, 16'h0100, 4'd1);
      resolve(3'd5, 1'b1, 16'h0010, 16'h0100, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
      chk("lt_s", 32'(taken), 32'd1);
      resolve(3'd5, 1'b0, 16'h0010, 16'h0100, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
      chk("lt_u", 32'(taken), 32'd0);
      resolve(3'd2, 1'b1, 16'h0010, 16'h0100, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
      chk("ge_s", 32'(taken), 32'd0);
      resolve(3'd2, 1'b0, 16'h0010, 16'h0100, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
      chk("ge_u", 32'(taken), 32'd1);
      resolve(3'd3, 1'b1, 16'h0010, 16'h0100, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
      chk("le_s", 32'(taken), 32'd1);
      resolve(3'd3, 1'b0, 16'h0010, 16'h0100, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
      chk("le_u", 32'(taken), 32'd0);
      resolve(3'd2, 1'b1, 16'h0010, 16'h0100, 1'b1, 16'h8000, 16'h8000, 1'b0);
      chk("ge_eq", 32'(taken), 32'd1);
      resolve(3'd1, 1'b0, 16'h0010, 16'h0100, 1'b1, 16'h0001, 16'h0002, 1'b0);
      chk("ne", 32'(taken), 32'd1);
      resolve(3'd6, 1'b0, 16'h0010, 16'h0100, 1'b1, 16'h0000, 16'h0000, 1'b1);
      chk("carry", 32'(taken), 32'd1);
      chk_out("cmp_end", 1'b1, 1'b0, 16'h0100, 4'd1);

      // 4: PHT[3] training
      chk_pred("pht3_init", 16'h0003, 1'b0);
      resolve(3'd7, 1'b0, 16'h0003, 16'h0030, 1'b0, 16'h0, 16'h0, 1'b0);
      chk_out("tk1", 1'b1, 1'b1, 16'h0030, 4'd2);
      chk_pred("pht3_tk1", 16'h0003, 1'b1);
      resolve(3'd7, 1'b0, 16'h0003, 16'h0030, 1'b1, 16'h0, 16'h0, 1'b0);
      resolve(3'd7, 1'b0, 16'h0003, 16'h0030, 1'b1, 16'h0, 16'h0, 1'b0);
      resolve(3'd7, 1'b0, 16'h0003, 16'h0030, 1'b1, 16'h0, 16'h0, 1'b0);
      chk_out("tk4", 1'b1, 1'b0, 16'h0030, 4'd2);
      resolve(3'd0, 1'b0, 16'h0003, 16'h0030, 1'b1, 16'h0001, 16'h0002, 1'b0);
      chk_out("nt1", 1'b0, 1'b1, 16'h0004, 4'd3);
      chk_pred("pht3_nt1", 16'h0003, 1'b1);
      resolve(3'd0, 1'b0, 16'h0003, 16'h0030, 1'b1, 16'h0001, 16'h0002, 1'b0);
      chk_out("nt2", 1'b0, 1'b1, 16'h0004, 4'd4);
      chk_pred("pht3_nt2", 16'h0003, 1'b0);

      // 5: stall holds everything, then fall-through wrap
      stall = 1'b1;
      resolve(3'd7, 1'b0, 16'h0003, 16'h0077, 1'b0, 16'h0, 16'h0, 1'b0);
      chk_out("stall", 1'b0, 1'b1, 16'h0004, 4'd4);
      chk_pred("pht3_stall", 16'h0003, 1'b0);
      stall = 1'b0;
      resolve(3'd0, 1'b0, 16'hFFFF, 16'h0077, 1'b0, 16'h0001, 16'h0002, 1'b0);
      chk_out("wrap", 1'b0, 1'b0, 16'h0000, 4'd4);

      // 6: reset with a branch in flight
      reset = 1'b1;
      resolve(3'd7, 1'b0, 16'h0007, 16'h0055, 1'b0, 16'h0, 16'h0, 1'b0);
      reset = 1'b0;
      chk_out("rst_mid", 1'b0, 1'b0, 16'h0000, 4'd0);
      chk_pht_all_wnt("rst_mid");

      // counter saturation
      for (int i = 0; i < 15; i++)
         resolve(3'd7, 1'b0, 16'h0008, 16'h0080, 1'b0, 16'h0, 16'h0, 1'b0);
      chk("cnt_full", 32'(mis_cnt), 32'hF);
      resolve(3'd7, 1'b0, 16'h0008, 16'h0080, 1'b0, 16'h0, 16'h0, 1'b0);
      chk_out("cnt_sat", 1'b1, 1'b1, 16'h0080, 4'hF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
